// File: rtl/srp16_pkg.sv
// Shared types and constants for the SRP16 instruction fetch path.
package srp16_pkg;

    typedef enum logic [1:0] {
        FETCH_LO   = 2'd0,
        FETCH_HI   = 2'd1,
        WAIT_SPACE = 2'd2
    } fetch_state_t;

    localparam logic [15:0] SRP16_RESET_PC   = 16'h0000;
    localparam logic [15:0] SRP16_WORD_BYTES = 16'd2;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } instr_entry_t;

    // Byte address arithmetic; wraps naturally at 16 bits.
    function automatic logic [15:0] byte_addr_add(input logic [15:0] addr, input logic [15:0] offset);
        return addr + offset;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of assembled instruction words with a registered head.
// Clear wins over push/pop; the head register is preloaded so it is valid the cycle count goes nonzero.
module instr_fifo
    import srp16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  instr_entry_t             push_data,
    input  logic                     pop,
    output instr_entry_t             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    instr_entry_t       mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW-1:0]      rd_ptr_nx_s;
    logic [AW:0]        count_r;
    logic [AW:0]        count_nx_s;
    instr_entry_t       head_r;
    instr_entry_t       head_nx_s;
    logic               valid_r;
    logic               push_s;
    logic               pop_s;

    // Qualified push/pop, next occupancy and next head entry.
    always_comb begin
        pop_s       = pop && (count_r != {(AW+1){1'b0}});
        push_s      = push && ((count_r < FULL_COUNT) || pop_s);
        count_nx_s  = count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
        head_nx_s   = head_r;
        if (pop_s) begin
            rd_ptr_nx_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end
        // The word being written this cycle becomes head when it lands at the new read slot.
        if (count_nx_s == {(AW+1){1'b0}}) begin
            head_nx_s = head_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
            head_nx_s = push_data;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            head_r   <= '{instr: 16'h0000, pc: 16'h0000};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            head_r   <= head_nx_s;
            valid_r  <= (count_nx_s != {(AW+1){1'b0}});
        end
    end

    assign head  = head_r;
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: fetches byte pairs, assembles 16-bit words low byte first,
// and queues them with their byte address for decode. Flush redirects fetch.
module instr_prefetch
    import srp16_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = SRP16_RESET_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [15:0]              mem_addr,
    output logic                     mem_read,
    input  logic                     mem_ready,
    input  logic [7:0]               mem_din,
    input  logic                     flush,
    input  logic [15:0]              flush_addr,
    output logic                     instr_valid,
    output logic [15:0]              instr,
    output logic [15:0]              instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fetch_state_t   state_r;
    fetch_state_t   state_nx_s;
    logic [15:0]    fetch_pc_r;
    logic [15:0]    fetch_pc_nx_s;
    logic [7:0]     lo_byte_r;
    logic [7:0]     lo_byte_nx_s;
    logic [15:0]    mem_addr_r;
    logic [15:0]    mem_addr_nx_s;
    logic           mem_read_r;
    logic           mem_read_nx_s;
    logic           push_s;
    logic           pop_s;
    logic           clear_s;
    logic [AW:0]    count_s;
    logic [AW:0]    post_count_s;
    instr_entry_t   push_data_s;
    instr_entry_t   head_s;
    logic           head_valid_s;

    // Fetch FSM next state, byte assembly and next memory request.
    always_comb begin
        state_nx_s    = state_r;
        fetch_pc_nx_s = fetch_pc_r;
        lo_byte_nx_s  = lo_byte_r;
        push_s        = 1'b0;
        clear_s       = 1'b0;
        pop_s         = head_valid_s && instr_ready;
        post_count_s  = count_s + (AW+1)'(1'b1) - (AW+1)'(pop_s);
        push_data_s   = '{instr: {mem_din, lo_byte_r}, pc: fetch_pc_r};
        if (flush) begin
            clear_s       = 1'b1;
            state_nx_s    = FETCH_LO;
            fetch_pc_nx_s = flush_addr;
            lo_byte_nx_s  = 8'h00;
        end else begin
            case (state_r)
                FETCH_LO: begin
                    if (mem_ready) begin
                        lo_byte_nx_s = mem_din;
                        state_nx_s   = FETCH_HI;
                    end else begin
                        state_nx_s   = FETCH_LO;
                    end
                end
                FETCH_HI: begin
                    if (mem_ready) begin
                        push_s        = 1'b1;
                        fetch_pc_nx_s = byte_addr_add(fetch_pc_r, SRP16_WORD_BYTES);
                        if (post_count_s < FULL_COUNT) begin
                            state_nx_s = FETCH_LO;
                        end else begin
                            state_nx_s = WAIT_SPACE;
                        end
                    end else begin
                        state_nx_s = FETCH_HI;
                    end
                end
                WAIT_SPACE: begin
                    if (count_s < FULL_COUNT) begin
                        state_nx_s = FETCH_LO;
                    end else begin
                        state_nx_s = WAIT_SPACE;
                    end
                end
                default: begin
                    state_nx_s = FETCH_LO;
                end
            endcase
        end
        // Memory request is registered from the next state so it holds steady while waiting.
        mem_read_nx_s = (state_nx_s != WAIT_SPACE);
        if (state_nx_s == FETCH_HI) begin
            mem_addr_nx_s = byte_addr_add(fetch_pc_nx_s, 16'd1);
        end else begin
            mem_addr_nx_s = fetch_pc_nx_s;
        end
    end

    // FSM state, fetch address, low-byte holding and memory request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= FETCH_LO;
            fetch_pc_r <= RESET_PC;
            lo_byte_r  <= 8'h00;
            mem_addr_r <= RESET_PC;
            mem_read_r <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            lo_byte_r  <= lo_byte_nx_s;
            mem_addr_r <= mem_addr_nx_s;
            mem_read_r <= mem_read_nx_s;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .valid     (head_valid_s),
        .count     (count_s)
    );

    assign mem_addr    = mem_addr_r;
    assign mem_read    = mem_read_r;
    assign instr_valid = head_valid_s;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;
    assign count       = count_s;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a table of fetch/flush/pop vectors plus
// hand-written sequences for back-pressure, wait states, flush, wrap and reset.
module tb_instr_prefetch;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_ready;
    logic [7:0]  mem_din;
    logic        flush;
    logic [15:0] flush_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  count;

    logic [7:0]  mem_b [0:65535];
    int          n_tests;
    int          n_fail;

    typedef struct {
        logic        do_flush;
        logic [15:0] faddr;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs [9];

    instr_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_ready   (mem_ready),
        .mem_din     (mem_din),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    assign mem_din = mem_b[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !instr_valid; i++) step();
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_count(input logic [2:0] target, input int max_cycles);
        for (int i = 0; i < max_cycles && count != target; i++) step();
        chk("wait_count", {29'd0, count}, {29'd0, target});
    endtask

    task automatic pop_one();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = a[15:0];
            mem_b[a] = av[7:0] ^ av[15:8];
        end
        mem_b[0] = 8'h21; mem_b[1] = 8'h43; mem_b[2] = 8'h65; mem_b[3] = 8'h87;

        vecs[0] = '{1'b0, 16'h0000, 16'h4321, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 16'h8765, 16'h0002};
        vecs[2] = '{1'b0, 16'h0000, 16'h0504, 16'h0004};
        vecs[3] = '{1'b1, 16'h0101, 16'h0300, 16'h0101};
        vecs[4] = '{1'b0, 16'h0000, 16'h0502, 16'h0103};
        vecs[5] = '{1'b1, 16'h1234, 16'h2726, 16'h1234};
        vecs[6] = '{1'b1, 16'h00FE, 16'hFFFE, 16'h00FE};
        vecs[7] = '{1'b0, 16'h0000, 16'h0001, 16'h0100};
        vecs[8] = '{1'b1, 16'h2001, 16'h2221, 16'h2001};

        reset = 1'b1; mem_ready = 1'b0; flush = 1'b0; flush_addr = 16'h0000; instr_ready = 1'b0;
        step();
        step();

        // Reset state and first-word latency with zero-wait memory.
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_pc", {16'd0, instr_pc}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd1);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
        reset = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("lat_valid_c1", {31'd0, instr_valid}, 32'd0);
        chk("lat_addr_hi", {16'd0, mem_addr}, 32'h0001);
        step();
        chk("lat_valid_c2", {31'd0, instr_valid}, 32'd1);
        chk("lat_instr", {16'd0, instr}, 32'h4321);

        // Back-pressure: fill, stall in WAIT_SPACE, resume after one pop.
        wait_count(3'd4, 20);
        step();
        step();
        chk("full_mem_read", {31'd0, mem_read}, 32'd0);
        chk("full_count", {29'd0, count}, 32'd4);
        pop_one();
        chk("pop_count", {29'd0, count}, 32'd3);
        chk("pop_instr", {16'd0, instr}, 32'h8765);
        chk("pop_pc", {16'd0, instr_pc}, 32'h0002);
        step();
        chk("resume_read", {31'd0, mem_read}, 32'd1);
        chk("resume_addr", {16'd0, mem_addr}, 32'h0008);
        wait_count(3'd4, 20);

        // Wait states during the upper-byte fetch.
        do_reset();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", {16'd0, mem_addr}, 32'h0001);
            chk("stall_read", {31'd0, mem_read}, 32'd1);
            chk("stall_count", {29'd0, count}, 32'd0);
        end
        mem_ready = 1'b1;
        step();
        chk("stall_done_count", {29'd0, count}, 32'd1);
        chk("stall_done_instr", {16'd0, instr}, 32'h4321);

        // Flush in FETCH_HI with two queued words and a coinciding mem_ready.
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("pre_flush_count", {29'd0, count}, 32'd2);
        flush = 1'b1; flush_addr = 16'h0101;
        step();
        flush = 1'b0;
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("flush_addr", {16'd0, mem_addr}, 32'h0101);
        chk("flush_read", {31'd0, mem_read}, 32'd1);
        wait_valid(10);
        chk("flush_instr", {16'd0, instr}, 32'h0300);
        chk("flush_pc", {16'd0, instr_pc}, 32'h0101);

        // Table: each record optionally flushes, then expects the head word and pops it.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_flush) begin
                flush = 1'b1; flush_addr = vecs[i].faddr;
                step();
                flush = 1'b0;
                chk("vec_flush_valid", {31'd0, instr_valid}, 32'd0);
            end
            wait_valid(20);
            chk("vec_instr", {16'd0, instr}, {16'd0, vecs[i].exp_instr});
            chk("vec_pc", {16'd0, instr_pc}, {16'd0, vecs[i].exp_pc});
            pop_one();
        end

        // Address wrap: word at 0xFFFF takes its upper byte from 0x0000.
        mem_b[16'hFFFF] = 8'hAA;
        mem_b[0] = 8'hBB;
        flush = 1'b1; flush_addr = 16'hFFFF;
        step();
        flush = 1'b0;
        wait_valid(10);
        chk("wrap_instr", {16'd0, instr}, 32'hBBAA);
        chk("wrap_pc", {16'd0, instr_pc}, 32'hFFFF);
        chk("wrap_next_addr", {16'd0, mem_addr}, 32'h0001);

        // Reset mid-fetch with three queued words; reset overrides a simultaneous flush.
        do_reset();
        wait_count(3'd3, 20);
        step();
        chk("mid_addr_hi", {16'd0, mem_addr}, 32'h0007);
        reset = 1'b1; flush = 1'b1; flush_addr = 16'h5555;
        step();
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_addr", {16'd0, mem_addr}, 32'h0000);
        chk("mid_rst_read", {31'd0, mem_read}, 32'd1);
        chk("mid_rst_instr", {16'd0, instr}, 32'h0000);
        reset = 1'b0; flush = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
